modular_inverse: RTL and testbench
==================================

# modular_inverse

Computes the modular inverse R = a⁻¹ mod p for an odd modulus p of up to Data_Width bits, using a one-step-per-cycle binary extended Euclidean algorithm. It is a standalone, iterative arithmetic unit for the Paillier datapath (key generation / decryption constant μ). Operands are accepted with a single-cycle valid strobe, and the result is returned with a single-cycle valid pulse.

## Interface
- Data_Width, default 256: operand and result width in bits.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on clk), despite the name.
- a  input  Data_Width  value to invert; required range 1 ≤ a < p.
- p  input  Data_Width  modulus; required odd and > 1.
- valid_in  input  1  start strobe; a and p are sampled in the same cycle.
- R  output  Data_Width  result a⁻¹ mod p, in range [0, p-1].
- valid_out  output  1  one-cycle pulse; R is valid in that cycle.
- busy  output  1  high while a computation is in progress.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on valid_in=1, latch the operands and initialise:
  - u=a, v=p, x1=1, x2=0
  - go to CALC.
- CALC: exactly one action per cycle, in this priority:
  1. u==1 or v==1 or u==0 or v==0 → go to DONE.
  2. u even → u=u>>1; x1 = x1 even ? x1>>1 : (x1+p)>>1.
  3. v even → v=v>>1; x2 = x2 even ? x2>>1 : (x2+p)>>1.
  4. u ≥ v → u=u-v; x1 = x1 ≥ x2 ? x1-x2 : x1+p-x2.
  5. otherwise → v=v-u; x2 = x2 ≥ x1 ? x2-x1 : x2+p-x1.
- DONE: set R and pulse valid_out, then return to IDLE.
  - R = x1 if u==1, else x2 if v==1, else 0.
- Width rules:
  - x1+p and x2+p use Data_Width+1 bits; the shifted result fits in Data_Width.
  - x1 and x2 always stay in [0, p-1].
- Invalid-input behaviour:
  - a=0 terminates immediately with R=0.
  - gcd(a,p)≠1 drives u or v to 0 and terminates with R=0.
  - a ≥ p is unsupported; the only requirements are that the unit terminates and returns to IDLE.
- a=1 or p... u==1 on entry → R=1.
- valid_in while busy=1 is ignored; the current computation is unaffected.

## Timing
- Reset values: R=0, valid_out=0, busy=0, state=IDLE; all internal registers cleared.
- Reset mid-computation aborts it; no valid_out is produced.
- Cycle sequence:
  - valid_in is sampled at edge T0.
  - busy=1 from the cycle after T0 until the cycle valid_out is high.
  - valid_out and R update on the same edge; busy=0 in that cycle.
- valid_out is high for exactly one cycle per accepted request.
- R holds its value until the next completion or reset.
- Latency is data dependent, bounded by 4·Data_Width+4 cycles from acceptance to valid_out.
- A new valid_in is accepted in the cycle valid_out is high, or any later cycle.

## Test plan
- a=3, p=7 → R=5 with one valid_out pulse; busy high throughout the computation, low after.
- a=10, p=17 → R=12. Also a=2, p=11 → R=6.
- a=1, p=0xefee431 → R=1 within ≤4 cycles.
- a=0x123456, p=0xefee431 (Data_Width=256) → (R·a) mod p == 1 and R < p; latency ≤ 1028 cycles.
- a=6, p=9 (not coprime) → R=0, valid_out pulses. a=0 → R=0.
- valid_in re-pulsed with a=5 while busy → ignored; original result returned.
- rst_n=1 mid-computation → valid_out never fires, R=0, busy=0; the next request computes correctly.

Source files
------------

// File: rtl/modular_inverse.sv
// Iterative a^-1 mod p (odd p) via binary extended Euclid, one reduction step per cycle.
// Latency data dependent (<= 4*Data_Width+4); valid_in ignored while busy, result pulsed on valid_out.
module modular_inverse #(
  parameter int Data_Width = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Data_Width-1:0] a,
  input  logic [Data_Width-1:0] p,
  input  logic                  valid_in,
  output logic [Data_Width-1:0] R,
  output logic                  valid_out,
  output logic                  busy
);

  typedef logic [Data_Width-1:0] word_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam word_t One = word_t'(1);

  state_t state_q;
  word_t  u_q, v_q, x1_q, x2_q, p_q;
  word_t  u_d, v_d, x1_d, x2_d;
  word_t  r_q;
  logic   valid_out_q, busy_q;
  logic   finished;
  word_t  x1_half, x2_half, x1_sub, x2_sub;

  assign finished = (u_q == One) || (v_q == One) || (u_q == '0) || (v_q == '0);

  // Odd coefficients get +p before halving so the division by 2 stays exact mod p.
  always_comb begin
    x1_half = x1_q[0] ? word_t'(({1'b0, x1_q} + {1'b0, p_q}) >> 1) : (x1_q >> 1);
    x2_half = x2_q[0] ? word_t'(({1'b0, x2_q} + {1'b0, p_q}) >> 1) : (x2_q >> 1);
    // Wrap-around in Data_Width bits is harmless: the true difference is below p.
    x1_sub  = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q + p_q - x2_q);
    x2_sub  = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q + p_q - x1_q);
  end

  always_comb begin
    u_d  = u_q;
    v_d  = v_q;
    x1_d = x1_q;
    x2_d = x2_q;
    if (!u_q[0]) begin
      u_d  = u_q >> 1;
      x1_d = x1_half;
    end else if (!v_q[0]) begin
      v_d  = v_q >> 1;
      x2_d = x2_half;
    end else if (u_q >= v_q) begin
      u_d  = u_q - v_q;
      x1_d = x1_sub;
    end else begin
      v_d  = v_q - u_q;
      x2_d = x2_sub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      p_q         <= '0;
      r_q         <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            u_q     <= a;
            v_q     <= p;
            x1_q    <= One;
            x2_q    <= '0;
            p_q     <= p;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (finished) begin
            state_q <= DONE;
          end else begin
            u_q  <= u_d;
            v_q  <= v_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
          end
        end
        DONE: begin
          r_q         <= (u_q == One) ? x1_q : ((v_q == One) ? x2_q : '0);
          valid_out_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign R         = r_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_modular_inverse.sv
// Directed bench for modular_inverse with hand-computed inverses and protocol checks.
`timescale 1ns/1ps
module tb_modular_inverse;

  localparam int W = 256;
  localparam int MaxLat = 4 * W + 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, p;
  logic         valid_in;
  logic [W-1:0] R;
  logic         valid_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  modular_inverse #(.Data_Width(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .p(p), .valid_in(valid_in),
    .R(R), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [W-1:0] av, input logic [W-1:0] pv);
    @(negedge clk);
    a = av;
    p = pv;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Waits for valid_out, tracking that busy stays high until the completing cycle.
  task automatic wait_done(input string tag, output int lat);
    bit got = 0;
    bit busy_ok = 1;
    lat = 0;
    if (busy !== 1'b1) busy_ok = 0;
    for (int i = 1; i <= MaxLat + 8; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        got = 1;
        lat = i;
        break;
      end
      if (busy !== 1'b1) busy_ok = 0;
    end
    check({tag, "_done"}, W'(got), W'(1));
    check({tag, "_busy_during"}, W'(busy_ok), W'(1));
    check({tag, "_busy_at_done"}, W'(busy), W'(0));
  endtask

  task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] pv,
                     input logic [W-1:0] exp_r, input int max_lat);
    int lat;
    start(av, pv);
    wait_done(tag, lat);
    check({tag, "_R"}, R, exp_r);
    check({tag, "_lat_ok"}, W'(lat <= max_lat), W'(1));
    @(negedge clk);
    check({tag, "_pulse_single"}, W'(valid_out), W'(0));
    check({tag, "_busy_after"}, W'(busy), W'(0));
    check({tag, "_R_hold"}, R, exp_r);
  endtask

  initial begin
    int lat;
    bit fired;
    logic [63:0] prod;
    rst_n = 1'b1;
    a = '0;
    p = '0;
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_R", R, '0);
    check("rst_valid_out", W'(valid_out), W'(0));
    check("rst_busy", W'(busy), W'(0));
    rst_n = 1'b0;

    run("inv3_7", W'(3), W'(7), W'(5), MaxLat);
    run("inv10_17", W'(10), W'(17), W'(12), MaxLat);
    run("inv2_11", W'(2), W'(11), W'(6), MaxLat);
    run("inv1", W'(1), W'(32'h0efee431), W'(1), 4);
    run("gcd6_9", W'(6), W'(9), W'(0), MaxLat);
    run("zero_a", W'(0), W'(17), W'(0), MaxLat);

    start(W'(32'h123456), W'(32'h0efee431));
    wait_done("big", lat);
    check("big_lat_ok", W'(lat <= MaxLat), W'(1));
    check("big_R_lt_p", W'(R < W'(32'h0efee431)), W'(1));
    prod = (R[63:0] * 64'h123456) % 64'h0efee431;
    check("big_R_times_a", W'(prod), W'(1));

    // A second strobe while busy must not disturb the running computation.
    start(W'(10), W'(17));
    a = W'(5);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done("busy_ignore", lat);
    check("busy_ignore_R", R, W'(12));

    start(W'(32'h123456), W'(32'h0efee431));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("abort_R", R, '0);
    check("abort_busy", W'(busy), W'(0));
    fired = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) fired = 1;
    end
    check("abort_no_valid", W'(fired), W'(0));
    run("after_abort", W'(2), W'(11), W'(6), MaxLat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
